ra_guard_unit: RTL

//  Parametrised return-address protection unit for the execute stage, used alongside the branch unit.

---
 rtl/ra_guard_unit_if.sv | 37 +++
 rtl/ra_guard_unit.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/ra_guard_unit_if.sv
// Control-flow handshake bundle between the branch unit and the return-address guard.
// The branch unit drives the master side; the guard consumes the slave side.
interface ra_guard_if #(
    parameter int unsigned VLEN  = 32,
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic            en_i;
    logic            strict_i;
    logic            valid_i;
    logic            is_call_i;
    logic            is_ret_i;
    logic [VLEN-1:0] link_addr_i;
    logic [VLEN-1:0] ret_target_i;
    logic            key_wr_i;
    logic [VLEN-2:0] key_i;
    logic            clr_crash_i;
    logic [VLEN-1:0] enc_link_o;
    logic [VLEN-1:0] target_o;
    logic            violation_o;
    logic            crash_o;
    logic [CW-1:0]   depth_o;
    logic            key_pending_o;

    modport master (
        output en_i, strict_i, valid_i, is_call_i, is_ret_i, link_addr_i, ret_target_i,
               key_wr_i, key_i, clr_crash_i,
        input  enc_link_o, target_o, violation_o, crash_o, depth_o, key_pending_o
    );

    modport slave (
        input  en_i, strict_i, valid_i, is_call_i, is_ret_i, link_addr_i, ret_target_i,
               key_wr_i, key_i, clr_crash_i,
        output enc_link_o, target_o, violation_o, crash_o, depth_o, key_pending_o
    );
endinterface

// File: rtl/ra_guard_unit.sv
// Return-address guard: XOR link encoding with a deferred-rotation key, a circular
// shadow return stack, and a sticky crash state that zeroes jump targets until cleared.
module ra_guard_unit #(
    parameter int unsigned     VLEN      = 32,
    parameter int unsigned     DEPTH     = 8,
    parameter logic [VLEN-1:0] KEY_RESET = 32'h73fa06c2,
    parameter bit              OVF_WRAP  = 1'b1
) (
    input  logic     clk_i,
    input  logic     rst_i,
    ra_guard_if.slave g
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic {
        KEY_IDLE = 1'b0,
        KEY_PEND = 1'b1
    } key_state_e;

    key_state_e      kst_q, kst_d;
    logic [VLEN-2:0] key_q, key_d;
    logic [VLEN-2:0] pend_key_q, pend_key_d;
    logic [VLEN-1:0] mem_q [DEPTH];
    logic [VLEN-1:0] mem_d [DEPTH];
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            crash_q, crash_d;
    logic            viol_q, viol_d;

    logic            do_call, do_ret, ret_enc, empty, full, key_ok;
    logic [PW-1:0]   top_idx;
    logic [VLEN-1:0] top, dec_tgt;

    assign do_call = g.en_i & g.valid_i & g.is_call_i;
    assign do_ret  = g.en_i & g.valid_i & g.is_ret_i;
    assign ret_enc = g.ret_target_i[VLEN-1];
    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(DEPTH));
    assign top_idx = ptr_q - 1'b1;
    assign top     = mem_q[top_idx];
    // Key may only change while no encoded link can be live on the stack.
    assign key_ok  = g.en_i & empty & ~do_call;

    always_comb begin
        dec_tgt = g.ret_target_i;
        if (ret_enc) begin
            dec_tgt = {1'b0, g.ret_target_i[VLEN-2:1] ^ key_q[VLEN-2:1], 1'b0};
        end
    end

    always_comb begin
        g.enc_link_o = g.link_addr_i;
        if (g.en_i && g.is_call_i) begin
            g.enc_link_o = {1'b1, g.link_addr_i[VLEN-2:0] ^ key_q};
        end
        g.target_o = g.ret_target_i;
        if (g.en_i && g.valid_i && crash_q) begin
            g.target_o = '0;
        end else if (g.en_i && g.is_ret_i) begin
            g.target_o = dec_tgt;
        end
    end

    always_comb begin
        mem_d   = mem_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        viol_d  = 1'b0;
        crash_d = crash_q;

        if (do_ret) begin
            if (!ret_enc && g.strict_i) begin
                viol_d = 1'b1;
            end
            if (empty) begin
                if (g.strict_i) viol_d = 1'b1;
            end else if (top[VLEN-1:1] != dec_tgt[VLEN-1:1]) begin
                viol_d = 1'b1;
            end
        end

        // Coroutine swap on a non-empty stack replaces the top in place.
        if (do_call && do_ret && !empty) begin
            mem_d[top_idx] = g.link_addr_i;
        end else if (do_call) begin
            if (!full || OVF_WRAP) begin
                mem_d[ptr_q] = g.link_addr_i;
                ptr_d        = ptr_q + 1'b1;
                if (!full) cnt_d = cnt_q + 1'b1;
            end else begin
                viol_d = 1'b1;
            end
        end else if (do_ret && !empty) begin
            ptr_d = top_idx;
            cnt_d = cnt_q - 1'b1;
        end

        if (g.en_i && g.clr_crash_i) begin
            crash_d = 1'b0;
            cnt_d   = '0;
            ptr_d   = '0;
        end else if (viol_d) begin
            crash_d = 1'b1;
        end
    end

    always_comb begin
        kst_d      = kst_q;
        key_d      = key_q;
        pend_key_d = pend_key_q;
        case (kst_q)
            KEY_IDLE: begin
                if (g.key_wr_i) begin
                    if (key_ok) begin
                        key_d = g.key_i;
                    end else begin
                        pend_key_d = g.key_i;
                        kst_d      = KEY_PEND;
                    end
                end
            end
            KEY_PEND: begin
                if (g.key_wr_i) pend_key_d = g.key_i;
                if (key_ok) begin
                    key_d = g.key_wr_i ? g.key_i : pend_key_q;
                    kst_d = KEY_IDLE;
                end
            end
            default: kst_d = KEY_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            kst_q      <= KEY_IDLE;
            key_q      <= KEY_RESET[VLEN-2:0];
            pend_key_q <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            crash_q    <= 1'b0;
            viol_q     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            kst_q      <= kst_d;
            key_q      <= key_d;
            pend_key_q <= pend_key_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            crash_q    <= crash_d;
            viol_q     <= viol_d;
            mem_q      <= mem_d;
        end
    end

    assign g.violation_o   = viol_q;
    assign g.crash_o       = crash_q;
    assign g.depth_o       = cnt_q;
    assign g.key_pending_o = (kst_q == KEY_PEND);
endmodule
